// File: rtl/tst_pattern_gen_pkg.sv
// Shared modes, LFSR constants and FSM encoding for the test-pattern generator.
// Latency: n/a; backpressure: n/a.
package tst_pkg;

  localparam logic [2:0] MODE_COUNT  = 3'd0;
  localparam logic [2:0] MODE_SWAP   = 3'd1;
  localparam logic [2:0] MODE_WALK1  = 3'd2;
  localparam logic [2:0] MODE_PRBS15 = 3'd3;
  localparam logic [2:0] MODE_ALT    = 3'd4;

  localparam int              LFSR_W    = 15;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF;
  localparam int              LFSR_TAP_A = 14;
  localparam int              LFSR_TAP_B = 13;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tst_lfsr15.sv
// PRBS15 shift register; load forces the seed and wins over step.
// Latency: new value one edge after step/load; backpressure: holds when step is low.
module tst_lfsr15
  import tst_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [14:0] q
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      q <= LFSR_SEED;
    end else if (step) begin
      q <= {q[LFSR_W-2:0], q[LFSR_TAP_A] ^ q[LFSR_TAP_B]};
    end
  end

endmodule

// File: rtl/tst_pattern_gen.sv
// Burst test-pattern generator (count/swap/walk1/prbs15/alt); first word one edge after RUN entry.
// Backpressure: en low stalls the pattern (dout held, dvalid low); stop aborts, rst overrides all.
module tst_pattern_gen
  import tst_pkg::*;
#(
  parameter int OUT_W   = 8,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               stop,
  input  logic [2:0]         mode,
  input  logic [BURST_W-1:0] burst_len,
  output logic [OUT_W-1:0]   dout,
  output logic               dvalid,
  output logic               busy,
  output logic               done
);

  localparam int H = CNT_W / 2;

  state_t               state;
  logic [2:0]           mode_q;
  logic                 finite;
  logic [BURST_W-1:0]   remaining;
  logic [CNT_W-1:0]     cnt;
  logic                 done_pend;
  logic [LFSR_W-1:0]    lfsr;
  logic                 lfsr_load;
  logic                 lfsr_step;

  logic [CNT_W-1:0]     walk_idx;
  logic [OUT_W-1:0]     pat_count;
  logic [OUT_W-1:0]     pat_swap;
  logic [OUT_W-1:0]     pat_walk;
  logic [OUT_W-1:0]     pat_prbs;
  logic [OUT_W-1:0]     pat_alt;
  logic [OUT_W-1:0]     pattern;

  assign lfsr_load = (state == IDLE) && start;
  assign lfsr_step = (state == RUN) && en && !stop;

  tst_lfsr15 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .step (lfsr_step),
    .q    (lfsr)
  );

  assign walk_idx = cnt % CNT_W'(OUT_W);

  // Per-bit pattern taps; swap picks bit g of {cnt[H-1:0], cnt[CNT_W-1:H]}.
  for (genvar g = 0; g < OUT_W; g++) begin : g_pat
    assign pat_count[g] = cnt[g];
    assign pat_swap[g]  = cnt[(g + H) % CNT_W];
    assign pat_walk[g]  = (walk_idx == CNT_W'(g));
    assign pat_prbs[g]  = lfsr[g % LFSR_W];
    assign pat_alt[g]   = cnt[0] ^ ((g % 2) == 0);
  end

  always_comb begin
    pattern = '0;
    case (mode_q)
      MODE_COUNT:  pattern = pat_count;
      MODE_SWAP:   pattern = pat_swap;
      MODE_WALK1:  pattern = pat_walk;
      MODE_PRBS15: pattern = pat_prbs;
      MODE_ALT:    pattern = pat_alt;
      default:     pattern = '0;
    endcase
  end

  // After the last word the FSM is already IDLE but busy stays up one more
  // cycle so that done and the busy drop land together, one edge after dvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dout      <= '0;
      dvalid    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      remaining <= '0;
      mode_q    <= MODE_COUNT;
      finite    <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      dvalid <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          done      <= done_pend;
          done_pend <= 1'b0;
          busy      <= start;
          if (start) begin
            mode_q    <= mode;
            remaining <= burst_len;
            finite    <= (burst_len != '0);
            cnt       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (en) begin
            dout   <= pattern;
            dvalid <= 1'b1;
            cnt    <= cnt + CNT_W'(1);
            if (finite) begin
              remaining <= remaining - BURST_W'(1);
              if (remaining == BURST_W'(1)) begin
                done_pend <= 1'b1;
                state     <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
